fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the word-addressed instruction memory and downstream of execute. It owns the program counter and issues one read per instruction on the memory's address/read-strobe port, capturing the word one cycle later. It presents the instruction and its PC to decode through a valid/ready handshake, and accepts PC redirects (branch/jump targets) from execute.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- mem_addr  out  32  byte address of fetch; memory uses [31:2]
- mem_rstrb  out  1  read strobe; memory samples mem_addr on the same edge
- mem_rdata  in  32  read word, valid the cycle after mem_rstrb
- instr  out  32  fetched instruction
- instr_pc  out  32  byte address of instr
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  decode accepts instr this cycle
- redirect_valid  in  1  replace PC with redirect_pc
- redirect_pc  in  32  redirect target
- fetch_misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, HOLD, TRAP.
- IDLE: entered on reset; no read issued; next cycle → REQ.
- REQ: mem_addr = pc, mem_rstrb = 1; → WAIT.
- WAIT: mem_rdata valid; instr <= mem_rdata, instr_pc <= pc, instr_valid <= 1, pc <= pc + 4; → HOLD.
- HOLD: instr_valid = 1, instr/instr_pc stable; on instr_ready: instr_valid <= 0, → REQ.
- mem_addr = pc in all states; mem_rstrb = 1 only in REQ.
- pc + 4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Redirect (any state except IDLE/TRAP): pc <= redirect_pc, instr_valid <= 0, → REQ. In WAIT, the returning word is discarded. Redirect has priority over every state transition.
- Redirect with instr_valid & instr_ready in the same cycle: the handshake completes (decode keeps the instruction), then the redirect applies.
- Redirect in REQ: the issued read is abandoned; its data is never captured.
- Reset mid-operation: any in-flight read is discarded; the block returns to IDLE with reset values.

## Timing
- Reset values: pc = RESET_PC, state = IDLE, mem_rstrb = 0, mem_addr = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, fetch_misaligned = 0.
- First mem_rstrb occurs 2 cycles after resetn rises. instr_valid rises 2 cycles after the strobe (REQ → WAIT → HOLD).
- Steady state with instr_ready held high: one instruction per 3 cycles.
- Redirect to mem_rstrb at the new target: 1 cycle. Redirect to instr_valid: 3 cycles.
- instr and instr_pc are registered and change only on the WAIT → HOLD transition or on reset.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0] != 0 causes the following:
  - → TRAP; fetch_misaligned <= 1.
  - instr_valid <= 0.
  - No further mem_rstrb is issued. Only reset exits TRAP.
- Not defined: redirect_pc[1:0] is forced to 2'b00 on load. TRAP is unreachable, and fetch_misaligned is tied to 0.

## Structure
- Shared package fetch_pkg: state encoding constants (IDLE, REQ, WAIT, HOLD, TRAP), default RESET_PC, instruction width.
- One sub-module, fetch_pc: the PC register with reset load, +4 increment and redirect mux, plus alignment handling under the macro. State machine and output registers live in fetch_unit.

## Test plan
- Reset release, RESET_PC = 0, memory word0 = 32'h0000_00B3, instr_ready = 1 → mem_rstrb at cycle 2 with mem_addr = 0; instr_valid at cycle 4 with instr = 32'h0000_00B3, instr_pc = 0; next strobe at mem_addr = 4.
- instr_ready = 0 for 5 cycles while HOLD → instr/instr_pc stable, no mem_rstrb. Ready asserted → next strobe one cycle later at pc + 4.
- redirect_valid in WAIT with redirect_pc = 32'h20 → fetched word discarded; next strobe at 32'h20; instr_pc = 32'h20 three cycles after the redirect.
- redirect in the same cycle as a HOLD handshake → decode receives the held instruction once; next instr_pc = redirect target.
- Redirect to 32'hFFFF_FFFC → instr_pc = 32'hFFFF_FFFC, then next fetch at mem_addr = 0.
- Redirect to 32'h0000_0006:
  - with FETCH_MISALIGN_TRAP_EN → fetch_misaligned = 1 next cycle, no mem_rstrb until reset.
  - without it → fetch at mem_addr = 32'h4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, widths, reset PC.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    TRAP = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset load, +4 step, redirect load.
// FETCH_MISALIGN_TRAP_EN: report misaligned targets instead of silently aligning them.
module fetch_pc
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc,
  output logic            misaligned_c
);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned_c = |load_pc[1:0];

  // Target is kept verbatim; the FSM parks in TRAP so it is never fetched.
  always_ff @(posedge clk) begin
    if (!resetn)   pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc + XLEN'(4);
  end
`else
  assign misaligned_c = 1'b0;

  // Low address bits are dropped so every fetch stays word aligned.
  always_ff @(posedge clk) begin
    if (!resetn)   pc <= RESET_PC;
    else if (load) pc <= load_pc & ~XLEN'(3);
    else if (inc)  pc <= pc + XLEN'(4);
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one memory read per instruction, valid/ready to decode, redirects.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets park the unit in TRAP.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_rstrb,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                fetch_misaligned
);

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] pc;
  logic            redirect_ok;
  logic            misaligned_c;
  logic            pc_inc;
  logic            pc_load;
  logic            capture;

  fetch_pc u_pc (
    .clk          (clk),
    .resetn       (resetn),
    .inc          (pc_inc),
    .load         (pc_load),
    .load_pc      (redirect_pc),
    .pc           (pc),
    .misaligned_c (misaligned_c)
  );

  assign mem_addr    = pc;
  assign redirect_ok = redirect_valid && (state != IDLE) && (state != TRAP);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Redirect overrides every other transition.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT:    next_state = HOLD;
      HOLD:    if (instr_ready) next_state = REQ;
      TRAP:    next_state = TRAP;
      default: next_state = IDLE;
    endcase
    if (redirect_ok) next_state = misaligned_c ? TRAP : REQ;
  end

  always_comb begin
    pc_inc  = 1'b0;
    capture = 1'b0;
    pc_load = redirect_ok;
    if (state == WAIT && !redirect_ok) begin
      pc_inc  = 1'b1;
      capture = 1'b1;
    end
  end

  // Strobe is registered from next_state so it is high exactly while in REQ.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_rstrb   <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      mem_rstrb <= (next_state == REQ);
      if (capture) begin
        instr       <= mem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (redirect_ok || (state == HOLD && instr_ready)) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!resetn)                          fetch_misaligned <= 1'b0;
    else if (redirect_ok && misaligned_c) fetch_misaligned <= 1'b1;
  end
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a cycle model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_addr         (mem_addr),
    .mem_rstrb        (mem_rstrb),
    .mem_rdata        (mem_rdata),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_00B3;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) mem_rdata <= mem_rstrb ? word(mem_addr) : 32'hDEAD_BEEF;

  // Reference model: 0 idle, 1 request, 2 waiting for data, 3 holding, 4 trapped.
  int          phase = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0;
  logic        m_valid = 0, m_mis = 0, m_rstrb = 0;

  task automatic model_edge();
    if (!resetn) begin
      phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 0; m_mis = 0;
    end else if (redirect_valid && phase != 0 && phase != 4) begin
      m_valid = 0;
      if (TRAP_EN && redirect_pc[1:0] != 2'b00) begin
        phase = 4; m_mis = 1; m_pc = redirect_pc;
      end else begin
        phase = 1; m_pc = TRAP_EN ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
      end
    end else begin
      case (phase)
        0: phase = 1;
        1: phase = 2;
        2: begin m_instr = word(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4; phase = 3; end
        3: if (instr_ready) begin m_valid = 0; phase = 1; end
        default: ;
      endcase
    end
    m_rstrb = (phase == 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_rstrb",   {31'b0, mem_rstrb},        {31'b0, m_rstrb});
    chk("mem_addr",    mem_addr,                   m_pc);
    chk("instr_valid", {31'b0, instr_valid},      {31'b0, m_valid});
    chk("instr",       instr,                      m_instr);
    chk("instr_pc",    instr_pc,                   m_ipc);
    chk("misaligned",  {31'b0, fetch_misaligned}, {31'b0, m_mis});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    resetn = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    repeat (3) step();
    chk("lit_rst_rstrb", {31'b0, mem_rstrb}, 32'h0);
    chk("lit_rst_addr", mem_addr, 32'h0);
    chk("lit_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("lit_rst_instr", instr, 32'h0);
    chk("lit_rst_ipc", instr_pc, 32'h0);

    resetn = 1'b1;
    step();
    chk("lit_first_strobe", {31'b0, mem_rstrb}, 32'h1);
    chk("lit_first_addr", mem_addr, 32'h0);
    step();
    chk("lit_wait_nostrobe", {31'b0, mem_rstrb}, 32'h0);
    step();
    chk("lit_first_valid", {31'b0, instr_valid}, 32'h1);
    chk("lit_first_instr", instr, 32'h0000_00B3);
    chk("lit_first_ipc", instr_pc, 32'h0);
    step();
    chk("lit_second_strobe", {31'b0, mem_rstrb}, 32'h1);
    chk("lit_second_addr", mem_addr, 32'h4);

    // Decode stall while holding.
    step();
    instr_ready = 1'b0;
    step();
    repeat (5) begin
      step();
      chk("lit_stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("lit_stall_ipc", instr_pc, 32'h4);
      chk("lit_stall_nostrobe", {31'b0, mem_rstrb}, 32'h0);
    end
    instr_ready = 1'b1;
    step();
    chk("lit_release_strobe", {31'b0, mem_rstrb}, 32'h1);
    chk("lit_release_addr", mem_addr, 32'h8);

    // Redirect while waiting for data.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("lit_wait_redir_addr", mem_addr, 32'h20);
    chk("lit_wait_redir_valid", {31'b0, instr_valid}, 32'h0);
    step();
    step();
    chk("lit_wait_redir_ipc", instr_pc, 32'h20);
    chk("lit_wait_redir_instr", instr, word(32'h20));

    // Redirect coinciding with a handshake.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("lit_hs_redir_valid", {31'b0, instr_valid}, 32'h0);
    chk("lit_hs_redir_addr", mem_addr, 32'h100);
    step();
    step();
    chk("lit_hs_redir_ipc", instr_pc, 32'h100);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("lit_top_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("lit_top_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_addr", mem_addr, 32'h0);

    // Misaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    if (TRAP_EN) begin
      chk("lit_trap_flag", {31'b0, fetch_misaligned}, 32'h1);
      repeat (3) begin
        step();
        chk("lit_trap_nostrobe", {31'b0, mem_rstrb}, 32'h0);
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
    end else begin
      chk("lit_align_strobe", {31'b0, mem_rstrb}, 32'h1);
      chk("lit_align_addr", mem_addr, 32'h4);
      chk("lit_align_flag", {31'b0, fetch_misaligned}, 32'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      resetn         = ($urandom_range(0, 299) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      redirect_pc = 32'hFFFF_FFFC;
      else if (r == 1) redirect_pc = ($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(0, 2));
      else             redirect_pc = $urandom & 32'h0000_FFFC;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
